// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers the
// returned instructions with their PC in a DEPTH-entry FIFO, and supports a
// redirect that flushes the queue and restarts fetching at a new PC.
module instruction_prefetch_queue #(
   parameter int unsigned           DEPTH      = 4,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       mem_req,
   output logic [ADDR_WIDTH-1:0]      mem_addr,
   input  logic                       mem_ack,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   output logic [DATA_WIDTH-1:0]      instruction_out,
   output logic [ADDR_WIDTH-1:0]      pc_out,
   output logic                       read,
   input  logic                       accept,
   input  logic                       redirect,
   input  logic [ADDR_WIDTH-1:0]      redirect_pc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]   pending_pc_q, pending_pc_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0]   data_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   data_mem_d [DEPTH];
   logic [ADDR_WIDTH-1:0]   pc_mem_q   [DEPTH];
   logic [ADDR_WIDTH-1:0]   pc_mem_d   [DEPTH];

   logic                    push;
   logic                    pop;
   logic [ADDR_WIDTH-1:0]   redirect_pc_al;
   logic                    unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign redirect_pc_al       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

   assign mem_req         = (state_q != IDLE);
   assign mem_addr        = fetch_pc_q;
   assign read            = (count_q != '0);
   assign count           = count_q;
   assign instruction_out = data_mem_q[rd_ptr_q];
   assign pc_out          = pc_mem_q[rd_ptr_q];

   // Queue update first so the FSM can decide on post-push/pop/flush occupancy.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      data_mem_d   = data_mem_q;
      pc_mem_d     = pc_mem_q;

      // redirect overrides both the memory return and the consumer pop
      push = (state_q == REQ) && mem_ack && !redirect;
      pop  = accept && read && !redirect;

      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            data_mem_d[wr_ptr_q] = mem_rdata;
            pc_mem_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end

      case (state_q)
         IDLE: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al;
               state_d    = REQ;
            end else if (count_d < DEPTH_C) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               if (redirect) begin
                  fetch_pc_d = redirect_pc_al;
                  state_d    = REQ;
               end else begin
                  fetch_pc_d = fetch_pc_q + PC_STEP;
                  state_d    = (count_d < DEPTH_C) ? REQ : IDLE;
               end
            end else if (redirect) begin
               // outstanding request must complete before the new PC is used
               pending_pc_d = redirect_pc_al;
               state_d      = DISCARD;
            end
         end
         DISCARD: begin
            if (redirect) begin
               pending_pc_d = redirect_pc_al;
            end
            if (mem_ack) begin
               fetch_pc_d = redirect ? redirect_pc_al : pending_pc_q;
               state_d    = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, fetch address and FIFO storage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         pending_pc_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_mem_q   <= '{default: '0};
         pc_mem_q     <= '{default: '0};
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_mem_q   <= data_mem_d;
         pc_mem_q     <= pc_mem_d;
      end
   end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Scoreboard bench for instruction_prefetch_queue: directed scenarios push
// expected PCs; a negedge monitor checks every popped head entry.
module tb_instruction_prefetch_queue;

   localparam logic [31:0] K = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_ack, read, accept, redirect;
   logic [31:0] mem_addr, mem_rdata, instruction_out, pc_out, redirect_pc;
   logic [2:0]  count;

   logic        mem_req2, read2;
   logic [31:0] mem_addr2, instruction_out2, pc_out2;
   logic [2:0]  count2;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned lat      = 0;
   int unsigned wcnt     = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mon_pc;
   bit          found;

   always #5 clk = ~clk;

   instruction_prefetch_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0)) u_dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .instruction_out(instruction_out), .pc_out(pc_out), .read(read),
      .accept(accept), .redirect(redirect), .redirect_pc(redirect_pc), .count(count));

   // free-running zero-latency memory, consumer always accepting
   instruction_prefetch_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFFFFF8)) u_dut2 (
      .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_req2),
      .mem_rdata(mem_addr2 ^ K), .instruction_out(instruction_out2), .pc_out(pc_out2), .read(read2),
      .accept(1'b1), .redirect(1'b0), .redirect_pc(32'h0), .count(count2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      accept   = 1'b0;
      redirect = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      chk(name, exp_q.size(), 0);
      accept = 1'b0;
   endtask

   task automatic wait_req_addr(input logic [31:0] a);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         found = (mem_req === 1'b1) && (mem_addr === a);
      end
      chk("wait_req_addr", {31'd0, found}, 32'd1);
   endtask

   // Memory model: acks after lat extra cycles of mem_req, single-cycle ack.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack === 1'b1 || mem_req !== 1'b1) begin
            mem_ack = 1'b0;
            wcnt    = 0;
         end
         if (mem_req === 1'b1) begin
            if (wcnt == lat) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_addr ^ K;
            end else begin
               wcnt++;
            end
         end
      end
   end

   // Monitor: every pop must match the oldest expected PC.
   always @(negedge clk) begin
      if (reset === 1'b0 && read === 1'b1 && accept === 1'b1 && redirect === 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got pc 0x%0h required no pop at %0t", pc_out, $time);
         end else begin
            mon_pc = exp_q.pop_front();
            chk("pop_pc", pc_out, mon_pc);
            chk("pop_instr", instruction_out, mon_pc ^ K);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      redirect_pc = '0;
      lat         = 0;

      // T1: reset values, zero-latency streaming, RESET_PC wrap on dut2
      do_reset();
      chk("rst_count", count, 0);
      chk("rst_read", read, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_instr", instruction_out, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_mem_addr2", mem_addr2, 32'hFFFFFFF8);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      accept = 1'b1;
      reset  = 1'b0;
      tick();
      chk("t1_req_rise", mem_req, 1);
      chk("t1_req_addr", mem_addr, 0);
      chk("t1_read_low", read, 0);
      tick();
      chk("t1_read_rise", read, 1);
      chk("t1_first_pc", pc_out, 0);
      chk("t1_first_instr", instruction_out, 32'hA5A5A5A5);
      chk("t6_pc2_0", pc_out2, 32'hFFFFFFF8);
      chk("t6_instr2_0", instruction_out2, 32'h5A5A5A5D);
      tick();
      chk("t1_second_pc", pc_out, 32'h4);
      chk("t6_pc2_1", pc_out2, 32'hFFFFFFFC);
      tick();
      chk("t6_pc2_wrap", pc_out2, 32'h0);
      chk("t6_instr2_wrap", instruction_out2, 32'hA5A5A5A5);
      tick();
      tick();
      accept = 1'b0;
      chk("t1_drained", exp_q.size(), 0);

      // T2: fill to DEPTH, IDLE when full, single pop restarts fetch
      do_reset();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("t2_full_count", count, 4);
      chk("t2_full_idle", mem_req, 0);
      chk("t2_full_addr", mem_addr, 32'h10);
      tick();
      chk("t2_stay_full", count, 4);
      chk("t2_stay_idle", mem_req, 0);
      exp_q.push_back(32'h0);
      accept = 1'b1;
      tick();
      accept = 1'b0;
      chk("t2_pop_count", count, 3);
      chk("t2_restart_req", mem_req, 1);
      chk("t2_restart_addr", mem_addr, 32'h10);
      chk("t2_new_head", pc_out, 32'h4);
      chk("t2_drained", exp_q.size(), 0);

      // T3: redirect while a slow request is outstanding -> DISCARD
      do_reset();
      lat   = 3;
      reset = 1'b0;
      wait_req_addr(32'h8);
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      chk("t3_hold_addr", mem_addr, 32'h8);
      chk("t3_hold_req", mem_req, 1);
      chk("t3_flush_count", count, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = (mem_addr !== 32'h8);
      end
      chk("t3_new_addr", mem_addr, 32'h200);
      chk("t3_no_enqueue", count, 0);
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h204);
      accept = 1'b1;
      wait_drain("t3_drained");

      // T4: redirect coinciding with mem_ack and accept, count=2
      do_reset();
      lat   = 0;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("t4_count2", count, 2);
      accept      = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      tick();
      chk("t4_flush_count", count, 0);
      chk("t4_flush_read", read, 0);
      chk("t4_new_addr", mem_addr, 32'h100);
      chk("t4_req", mem_req, 1);
      redirect = 1'b0;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      wait_drain("t4_drained");

      // T5: second redirect in DISCARD wins
      do_reset();
      lat   = 3;
      reset = 1'b0;
      wait_req_addr(32'h4);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      chk("t5_hold_addr", mem_addr, 32'h4);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = (mem_addr !== 32'h4);
      end
      chk("t5_latest_wins", mem_addr, 32'h80);
      chk("t5_count", count, 0);
      exp_q.push_back(32'h80);
      accept = 1'b1;
      wait_drain("t5_drained");

      // T6: reset mid-request abandons it
      do_reset();
      reset = 1'b0;
      wait_req_addr(32'h4);
      chk("t6_count1", count, 1);
      reset = 1'b1;
      tick();
      chk("t6_rst_req", mem_req, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_read", read, 0);
      chk("t6_rst_req2", mem_req2, 0);
      chk("t6_rst_count2", count2, 0);
      reset = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_prefetch_queue.md
Name: instruction_prefetch_queue

Overview:
- Fetch stage upstream of instruction_fetch_unit.
- Issues sequential word fetches to instruction memory and buffers the returned instructions in a DEPTH-entry FIFO.
- Presents the buffered instructions with their PC to the fetch unit through a valid/accept handshake.
- Supports a redirect that flushes the queue and restarts fetching at a new PC.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2).
- DATA_WIDTH, 32, instruction width.
- ADDR_WIDTH, 32, PC/address width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_addr  out  ADDR_WIDTH  fetch address; stable while mem_req=1.
- mem_ack  in  1  single-cycle completion; mem_rdata valid this cycle.
- mem_rdata  in  DATA_WIDTH  fetched instruction.
- instruction_out  out  DATA_WIDTH  head-of-queue instruction.
- pc_out  out  ADDR_WIDTH  PC of instruction_out.
- read  out  1  queue non-empty; instruction_out/pc_out valid.
- accept  in  1  consumer pops head when read=1; ignored when read=0.
- redirect  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  new fetch address; low 2 bits forced to 0.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset=1 at an edge gives: state=IDLE, fetch_pc=RESET_PC, FIFO pointers=0, count=0, read=0, mem_req=0, mem_addr=RESET_PC, instruction_out=0, pc_out=0.
  - Reset mid-transaction abandons the request. The memory side must tolerate mem_req dropping.
- States: IDLE, REQ, DISCARD.
  - mem_req=1 in REQ and DISCARD.
  - mem_addr=fetch_pc in REQ; mem_addr=held old address in DISCARD.
- At most one outstanding request at a time.
- IDLE:
  - Go to REQ next cycle if count_next<DEPTH and redirect=0.
  - With redirect=1: load fetch_pc=redirect_pc and go to REQ.
- REQ, no mem_ack:
  - Stay in REQ; address held.
  - redirect=1: latch redirect_pc into pending_pc, go to DISCARD. Address stays held.
- REQ, mem_ack=1, redirect=0:
  - Push {mem_rdata, fetch_pc}; fetch_pc+=4.
  - Stay in REQ if count_next<DEPTH, else go to IDLE.
  - Back-to-back fetches give 1 instruction/cycle when the consumer keeps up.
- REQ, mem_ack=1, redirect=1:
  - Drop the data; fetch_pc=redirect_pc; go to REQ.
- DISCARD:
  - On mem_ack: drop the data, fetch_pc=pending_pc, go to REQ.
  - redirect in DISCARD overwrites pending_pc. The latest redirect wins.
- count_next is occupancy after this cycle's push, pop and flush, so no overflow is possible.
- Queue:
  - Registered FIFO with head at instruction_out/pc_out.
  - A pushed entry is visible the cycle after mem_ack.
  - Pop occurs on accept&read.
  - Push and pop in the same cycle leave count unchanged. This includes count=DEPTH and count=1.
  - Pointers wrap modulo DEPTH.
  - read=(count!=0), computed combinationally from count.
- Redirect priority:
  - redirect beats both accept and mem_ack in the same cycle.
  - The queue empties next cycle (count=0, read=0) and no pop is counted.
- fetch_pc arithmetic is modulo 2^ADDR_WIDTH. 0xFFFFFFFC+4 wraps to 0.
- Full-queue latency: after a pop from a full queue in IDLE, mem_req rises the next cycle.

Test Plan:
- Reset then zero-latency memory (mem_ack on every cycle mem_req=1, rdata=addr^0xA5A5A5A5), accept held 1 -> mem_req rises 1 cycle after reset falls; read rises the following cycle with pc_out=0x0, instruction_out=0xA5A5A5A5; then pc 0x4, 0x8, ... on consecutive cycles.
- accept=0 with DEPTH=4 -> exactly 4 acks accepted; count=4; mem_req=0 (IDLE). Single accept pulse -> count=3, mem_req=1 next cycle at addr 0x10.
- Memory acks 3 cycles after request; redirect to 0x200 one cycle after request 0x8 issues -> state DISCARD; mem_addr held 0x8 until ack; that data never enqueued; next request addr 0x200; first read has pc_out=0x200.
- Redirect to 0x100 in the same cycle as mem_ack and accept with count=2 -> next cycle count=0, read=0; next mem_addr=0x100.
- Two redirects (0x40 then 0x80) during DISCARD -> only 0x80 fetched after the old ack.
- RESET_PC=0xFFFFFFF8, free-running memory -> pc_out sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0; reset asserted mid-request -> mem_req=0, count=0 the next cycle.
